// File: rtl/ifq_pkg.sv
// ifq_pkg: shared defaults and width helpers for the IF-stage instruction queue
package ifq_pkg;
  localparam int IFQ_WIDTH_DEF = 16;
  localparam int IFQ_DEPTH_DEF = 4;
  localparam logic [IFQ_WIDTH_DEF-1:0] IFQ_NOP_DEF = '0;
  function automatic int ifq_cw(input int depth);
    return $clog2(depth + 1);
  endfunction
  function automatic int ifq_pw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/ifq_ptr.sv
// ifq_ptr: modulo-DEPTH pointer with increment and clear
// Ports: clk, rst_n (async active-low), i_inc (advance), i_clr (to 0, wins over inc), o_ptr (current index)
module ifq_ptr
  import ifq_pkg::*;
#(
  parameter  int DEPTH = IFQ_DEPTH_DEF,
  localparam int PW    = ifq_pw(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_inc,
  input  logic          i_clr,
  output logic [PW-1:0] o_ptr
);
  logic [PW-1:0] r_ptr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_ptr <= '0;
    else if (i_clr) r_ptr <= '0;
    else if (i_inc) r_ptr <= (r_ptr == PW'(DEPTH - 1)) ? '0 : r_ptr + PW'(1);
  assign o_ptr = r_ptr;
endmodule

// File: rtl/if_instr_queue.sv
// if_instr_queue: I-cache to decode instruction queue with NOP substitution and flush
// Ports: clk, rst_n (async active-low); fetch_valid/fetch_instr/fetch_ready from I-cache;
//        flush, mode, stall control; instr_o/instr_valid to decode; count = occupancy.
// Optional: define IFQ_BYPASS_EN for zero-latency pass-through when the queue is empty.
module if_instr_queue
  import ifq_pkg::*;
#(
  parameter  int               WIDTH = IFQ_WIDTH_DEF,
  parameter  int               DEPTH = IFQ_DEPTH_DEF,
  parameter  logic [WIDTH-1:0] NOP   = WIDTH'(IFQ_NOP_DEF),
  localparam int               CW    = ifq_cw(DEPTH),
  localparam int               PW    = ifq_pw(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_valid,
  input  logic [WIDTH-1:0] fetch_instr,
  output logic             fetch_ready,
  input  logic             flush,
  input  logic             mode,
  input  logic             stall,
  output logic [WIDTH-1:0] instr_o,
  output logic             instr_valid,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    w_head, w_tail;
  logic             w_qvalid, w_byp, w_push, w_pop;
  assign fetch_ready = r_count < CW'(DEPTH);
  assign w_qvalid    = (r_count != '0) & mode & ~flush;
  assign w_pop       = w_qvalid & ~stall;
`ifdef IFQ_BYPASS_EN
  assign w_byp = (r_count == '0) & mode & ~flush & fetch_valid;
`else
  assign w_byp = 1'b0;
`endif
  // a bypassed word consumed by decode this cycle is not stored
  assign w_push      = fetch_valid & fetch_ready & ~flush & ~(w_byp & ~stall);
  assign instr_valid = w_qvalid | w_byp;
  assign instr_o     = w_qvalid ? r_mem[w_head] : w_byp ? fetch_instr : NOP;
  assign count       = r_count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_count <= '0;
    else r_count <= flush ? '0 : r_count + CW'(w_push) - CW'(w_pop);
  always_ff @(posedge clk)
    if (w_push) r_mem[w_tail] <= fetch_instr;
  ifq_ptr #(.DEPTH(DEPTH)) u_head (.clk, .rst_n, .i_inc(w_pop), .i_clr(flush), .o_ptr(w_head));
  ifq_ptr #(.DEPTH(DEPTH)) u_tail (.clk, .rst_n, .i_inc(w_push), .i_clr(flush), .o_ptr(w_tail));
endmodule

// File: tb/tb_if_instr_queue.sv
// tb_if_instr_queue: scoreboard bench for if_instr_queue (DEPTH 4 main, DEPTH 3 wrap)
module tb_if_instr_queue;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_valid, fetch_ready, flush, mode, stall, instr_valid;
  logic [15:0] fetch_instr, instr_o;
  logic [2:0]  count;
  logic        f3_valid, f3_ready, f3_v;
  logic [15:0] f3_instr, f3_o;
  logic [1:0]  f3_cnt;
  logic [15:0] sb[$];
  logic [15:0] src[5];
  int          checks = 0;
  int          errors = 0;
  always #5 clk = ~clk;
  if_instr_queue #(.WIDTH(16), .DEPTH(4)) u_dut (
    .clk, .rst_n, .fetch_valid, .fetch_instr, .fetch_ready, .flush, .mode, .stall,
    .instr_o, .instr_valid, .count
  );
  if_instr_queue #(.WIDTH(16), .DEPTH(3)) u_dut3 (
    .clk, .rst_n, .fetch_valid(f3_valid), .fetch_instr(f3_instr), .fetch_ready(f3_ready),
    .flush(1'b0), .mode(1'b1), .stall(1'b0), .instr_o(f3_o), .instr_valid(f3_v), .count(f3_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic fv, input logic [15:0] fi, input logic fl, input logic md,
                     input logic st, output logic acc);
    logic er, ev, byp;
    fetch_valid = fv;
    fetch_instr = fv ? fi : 16'hxxxx;
    flush = fl;
    mode = md;
    stall = st;
    @(negedge clk);
    er = sb.size() < 4;
    byp = 1'b0;
`ifdef IFQ_BYPASS_EN
    byp = sb.size() == 0 && md && !fl && fv;
`endif
    ev = (sb.size() != 0 && md && !fl) || byp;
    chk("ready", 32'(fetch_ready), 32'(er));
    chk("count", 32'(count), 32'(sb.size()));
    chk("valid", 32'(instr_valid), 32'(ev));
    chk("instr", 32'(instr_o), ev ? (byp ? 32'(fi) : 32'(sb[0])) : 32'h0);
    acc = fv && er && !fl;
    if (fl) sb.delete();
    else begin
      if (ev && !st && !byp) void'(sb.pop_front());
      if (acc && !(byp && !st)) sb.push_back(fi);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic drain(input int n);
    logic a;
    repeat (n) cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, a);
  endtask
  initial begin
    logic a;
    int idx;
    rst_n = 1'b0;
    fetch_valid = 1'b0;
    fetch_instr = '0;
    flush = 1'b0;
    mode = 1'b1;
    stall = 1'b0;
    f3_valid = 1'b0;
    f3_instr = '0;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_ready", 32'(fetch_ready), 1);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_instr", 32'(instr_o), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1'b1, 16'h1111, 1'b0, 1'b1, 1'b0, a);
    cyc(1'b1, 16'h2222, 1'b0, 1'b1, 1'b0, a);
    cyc(1'b1, 16'h3333, 1'b0, 1'b1, 1'b0, a);
    drain(2);
    src = '{16'h2001, 16'h2002, 16'h2003, 16'h2004, 16'h2005};
    idx = 0;
    repeat (6) begin
      cyc(1'b1, src[idx], 1'b0, 1'b1, 1'b1, a);
      if (a) idx++;
    end
    chk("full_count", 32'(count), 4);
    chk("full_ready", 32'(fetch_ready), 0);
    chk("full_accepted", 32'(idx), 4);
    repeat (8) begin
      cyc(idx < 5, idx < 5 ? src[idx] : 16'h0, 1'b0, 1'b1, 1'b0, a);
      if (a) idx++;
    end
    chk("drain_done", 32'(idx), 5);
    cyc(1'b1, 16'h4001, 1'b0, 1'b1, 1'b1, a);
    cyc(1'b1, 16'h4002, 1'b0, 1'b1, 1'b1, a);
    cyc(1'b1, 16'h4003, 1'b0, 1'b1, 1'b1, a);
    cyc(1'b1, 16'h4444, 1'b1, 1'b1, 1'b0, a);
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, a);
    chk("flush_count", 32'(count), 0);
    cyc(1'b1, 16'h5001, 1'b0, 1'b1, 1'b1, a);
    cyc(1'b1, 16'h5002, 1'b0, 1'b1, 1'b1, a);
    for (int i = 0; i < 5; i++)
      cyc(i == 1 || i == 3, 16'h5003 + 16'(i), 1'b0, 1'b0, 1'b0, a);
    chk("mode_count", 32'(count), 4);
    drain(5);
    cyc(1'b1, 16'h6001, 1'b0, 1'b1, 1'b1, a);
    cyc(1'b1, 16'h6002, 1'b0, 1'b1, 1'b1, a);
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_valid", 32'(instr_valid), 0);
    chk("arst_instr", 32'(instr_o), 0);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1'b1, 16'h7001, 1'b0, 1'b1, 1'b0, a);
    drain(2);
`ifdef IFQ_BYPASS_EN
    cyc(1'b1, 16'hABCD, 1'b0, 1'b1, 1'b0, a);
    chk("byp_count0", 32'(count), 0);
    cyc(1'b1, 16'hABCD, 1'b0, 1'b1, 1'b1, a);
    chk("byp_count1", 32'(count), 1);
    drain(2);
`endif
    for (int i = 0; i <= 10; i++) begin
      f3_valid = i < 10;
      f3_instr = 16'h3000 + 16'(i);
      @(negedge clk);
      chk("d3_ready", 32'(f3_ready), 1);
`ifdef IFQ_BYPASS_EN
      chk("d3_valid", 32'(f3_v), 32'(i < 10));
      chk("d3_count", 32'(f3_cnt), 0);
      if (i < 10) chk("d3_instr", 32'(f3_o), 32'h3000 + 32'(i));
`else
      chk("d3_valid", 32'(f3_v), 32'(i != 0));
      chk("d3_count", 32'(f3_cnt), 32'(i != 0));
      if (i != 0) chk("d3_instr", 32'(f3_o), 32'h3000 + 32'(i - 1));
`endif
      @(posedge clk);
      #1;
    end
    f3_valid = 1'b0;
    @(negedge clk);
    chk("d3_empty", 32'(f3_cnt), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
